// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request ports, register-file write port and RAW hazard query
// between the writeback stages and the shared register-file write arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 5
);
    logic              req0_valid, req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid, req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic [ADDR_W-1:0] chk_a1, chk_a2;
    logic              busy1, busy2;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output chk_a1, chk_a2,
        input  req0_ready, req1_ready, we3, a3, wd3, busy1, busy2
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  chk_a1, chk_a2,
        output req0_ready, req1_ready, we3, a3, wd3, busy1, busy2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (0) and load (1) writeback:
// one-entry buffer per requester, round-robin grant, registered write stage.
module regfile_wb_arbiter #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t [1:0]         req, ent;
    wr_t               gnt_ent;
    logic [1:0]        vld, full, grant, rdy;
    logic              last_grant;
    logic              we3_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] wd3_q;

    assign vld    = {bus.req1_valid, bus.req0_valid};
    assign req[0] = {bus.req0_addr, bus.req0_data};
    assign req[1] = {bus.req1_addr, bus.req1_data};

    // last_grant==1 means requester 1 won last, so requester 0 wins a tie.
    assign grant[0] = full[0] & (~full[1] | last_grant);
    assign grant[1] = full[1] & (~full[0] | ~last_grant);
    assign rdy      = ~full | grant;
    assign gnt_ent  = grant[1] ? ent[1] : ent[0];

    assign bus.req0_ready = rdy[0];
    assign bus.req1_ready = rdy[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
            ent  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (vld[i] && rdy[i]) begin
                    full[i] <= 1'b1;
                    ent[i]  <= req[i];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Address 0 is a hard-wired zero register: consume the entry, suppress we3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            last_grant <= 1'b1;
        end else if (|grant) begin
            we3_q      <= |gnt_ent.addr;
            a3_q       <= gnt_ent.addr;
            wd3_q      <= gnt_ent.data;
            last_grant <= grant[1];
        end else begin
            we3_q      <= 1'b0;
        end
    end

    assign bus.we3 = we3_q;
    assign bus.a3  = a3_q;
    assign bus.wd3 = wd3_q;

    function automatic logic pending(input logic [ADDR_W-1:0] a);
        return (a != '0) &&
               ((full[0] && ent[0].addr == a) ||
                (full[1] && ent[1].addr == a) ||
                (we3_q   && a3_q        == a));
    endfunction

    assign bus.busy1 = pending(bus.chk_a1);
    assign bus.busy2 = pending(bus.chk_a2);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes queued at drive
// time, popped and compared whenever we3 is seen.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(128), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(128), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]   a;
        logic [127:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   wcyc[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.we3) begin
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("wr_extra", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_a3", bus.a3, e.a);
                chk("wr_wd3", bus.wd3, e.d);
            end
        end
    end

    task automatic push(input logic [4:0] a, input logic [127:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int p, input logic [4:0] a, input logic [127:0] d, output int stalls);
        logic r;
        int   n;
        n = 0;
        stalls = 0;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
        end
        do begin
            @(negedge clk);
            r = (p == 0) ? bus.req0_ready : bus.req1_ready;
            @(posedge clk);
            if (!r) stalls++;
            n++;
        end while (!r && n < 50);
        if (!r) chk("send_timeout", r, 1'b1);
        #1;
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.we3) && n < 30) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int st, tot, h, e1;
        logic [127:0] va;
        bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
        bus.chk_a1 = 0; bus.chk_a2 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset with both buffers loaded and a write in the output stage
        bus.req0_valid = 1; bus.req0_addr = 10; bus.req0_data = 128'h10;
        bus.req1_valid = 1; bus.req1_addr = 11; bus.req1_data = 128'h11;
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(posedge clk); #1;
        chk("rst_pre_we3", bus.we3, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_we3", bus.we3, 1'b0);
        chk("rst_a3", bus.a3, 5'd0);
        chk("rst_wd3", bus.wd3, 128'd0);
        #1 rst = 1'b0;
        bus.chk_a1 = 11; bus.chk_a2 = 10;
        @(negedge clk);
        chk("rst_rdy0", bus.req0_ready, 1'b1);
        chk("rst_rdy1", bus.req1_ready, 1'b1);
        chk("rst_busy1", bus.busy1, 1'b0);
        chk("rst_busy2", bus.busy2, 1'b0);
        @(posedge clk); #1;

        // Single requester streaming
        push(5, 128'h11); push(6, 128'h22); push(7, 128'h33);
        wcyc.delete();
        send(0, 5, 128'h11, st); tot = st; h = cyc;
        send(0, 6, 128'h22, st); tot += st;
        send(0, 7, 128'h33, st); tot += st;
        chk("str_stalls", tot, 0);
        wait_drain();
        chk("str_nwr", wcyc.size(), 3);
        for (int i = 0; i < 3 && i < wcyc.size(); i++) chk("str_cyc", wcyc[i], h + 1 + i);

        // Contention from reset: strict 0,1,0,1 alternation
        pulse_rst();
        @(posedge clk); #1;
        va = {32{4'hA}};
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) push(24, va);
            else            push(3, 128'h1234);
        end
        wcyc.delete();
        bus.req0_valid = 1; bus.req0_addr = 24; bus.req0_data = va;
        bus.req1_valid = 1; bus.req1_addr = 3;  bus.req1_data = 128'h1234;
        e1 = 0;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1 if (j == 1) e1 = cyc;
            @(negedge clk);
            chk("con_rdy0", bus.req0_ready, (j % 2 == 1));
            chk("con_rdy1", bus.req1_ready, (j % 2 == 0));
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(posedge clk); #1;
        wait_drain();
        chk("con_nwr", wcyc.size(), 7);
        for (int i = 0; i < 7 && i < wcyc.size(); i++) chk("con_cyc", wcyc[i], e1 + 1 + i);

        // Address 0 is consumed without a write
        wcyc.delete();
        send(1, 0, 128'hFF, st);
        push(2, 128'h44);
        send(1, 2, 128'h44, st);
        wait_drain();
        chk("a0_nwr", wcyc.size(), 1);

        // Hazard query
        bus.chk_a1 = 25; bus.chk_a2 = 1;
        @(negedge clk);
        chk("hz_idle_b1", bus.busy1, 1'b0);
        @(posedge clk); #1;
        push(25, 128'h5555);
        send(0, 25, 128'h5555, st);
        chk("hz_buf_b1", bus.busy1, 1'b1);
        chk("hz_buf_b2", bus.busy2, 1'b0);
        bus.chk_a1 = 0;
        #1 chk("hz_zero_b1", bus.busy1, 1'b0);
        bus.chk_a1 = 25;
        @(posedge clk); #1;
        chk("hz_out_we3", bus.we3, 1'b1);
        chk("hz_out_b1", bus.busy1, 1'b1);
        chk("hz_out_b2", bus.busy2, 1'b0);
        @(posedge clk); #1;
        chk("hz_done_we3", bus.we3, 1'b0);
        chk("hz_done_b1", bus.busy1, 1'b0);
        wait_drain();

        // Async reset mid-stream drops the in-flight and buffered writes
        bus.chk_a1 = 9; bus.chk_a2 = 8;
        send(0, 8, 128'h88, st);
        send(0, 9, 128'h99, st);
        chk("ar_pre_we3", bus.we3, 1'b1);
        chk("ar_pre_b1", bus.busy1, 1'b1);
        rst = 1'b1;
        #1;
        chk("ar_we3", bus.we3, 1'b0);
        chk("ar_b1", bus.busy1, 1'b0);
        chk("ar_b2", bus.busy2, 1'b0);
        #1 rst = 1'b0;
        wcyc.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("ar_nwr", wcyc.size(), 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d exp 0", cyc);
        $fatal(1);
    end
endmodule
